// File: rtl/buzzer_tone_gen.sv
// Arbitrates live keypad and song player notes (live wins) and drives a passive
// buzzer with a square wave, inserting a silent articulation gap on every new or re-struck note.
module buzzer_tone_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int KEY_ID_BITS = 4,
    parameter int GAP_MS      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_ID_BITS-1:0] live_key_id,
    input  logic                   live_key_pressed,
    input  logic [KEY_ID_BITS-1:0] song_key_id,
    input  logic                   song_key_is_pressed,
    input  logic                   song_retrigger,
    output logic                   buzzer_out,
    output logic [KEY_ID_BITS-1:0] active_key_id,
    output logic                   sounding,
    output logic                   source_is_live
);

    // Half periods in clocks at 50 MHz; other clock rates are scaled with rounding.
    function automatic int half_at_50mhz(input int id);
        case (id)
            1:       return 95556;
            2:       return 85131;
            3:       return 75843;
            4:       return 71586;
            5:       return 63776;
            6:       return 56818;
            7:       return 50619;
            8:       return 90193;
            9:       return 80353;
            10:      return 67568;
            11:      return 60196;
            12:      return 53629;
            default: return 0;
        endcase
    endfunction

    function automatic int half_period(input int id);
        longint h;
        h = (longint'(half_at_50mhz(id)) * longint'(CLK_FREQ_HZ) + longint'(25_000_000))
            / longint'(50_000_000);
        if (h < 1) h = 1;
        return int'(h);
    endfunction

    function automatic logic key_valid(input logic [KEY_ID_BITS-1:0] id);
        return (int'(id) >= 1) && (int'(id) <= 12);
    endfunction

    localparam int GAP_CYCLES = GAP_MS * (CLK_FREQ_HZ / 1000);
    localparam int MAX_HALF   = half_period(1);
    localparam int PH_W       = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Terminal phase counts (half period minus one) for each valid key ID.
    localparam logic [PH_W-1:0] HM1_C4  = PH_W'(half_period(1) - 1);
    localparam logic [PH_W-1:0] HM1_D4  = PH_W'(half_period(2) - 1);
    localparam logic [PH_W-1:0] HM1_E4  = PH_W'(half_period(3) - 1);
    localparam logic [PH_W-1:0] HM1_F4  = PH_W'(half_period(4) - 1);
    localparam logic [PH_W-1:0] HM1_G4  = PH_W'(half_period(5) - 1);
    localparam logic [PH_W-1:0] HM1_A4  = PH_W'(half_period(6) - 1);
    localparam logic [PH_W-1:0] HM1_B4  = PH_W'(half_period(7) - 1);
    localparam logic [PH_W-1:0] HM1_CS4 = PH_W'(half_period(8) - 1);
    localparam logic [PH_W-1:0] HM1_DS4 = PH_W'(half_period(9) - 1);
    localparam logic [PH_W-1:0] HM1_FS4 = PH_W'(half_period(10) - 1);
    localparam logic [PH_W-1:0] HM1_GS4 = PH_W'(half_period(11) - 1);
    localparam logic [PH_W-1:0] HM1_AS4 = PH_W'(half_period(12) - 1);

    typedef enum logic [1:0] {
        S_SILENT,
        S_GAP,
        S_TONE
    } state_t;

    state_t                 state_q;
    logic [GAP_W-1:0]       gap_q;
    logic [PH_W-1:0]        phase_q;
    logic [PH_W-1:0]        half_m1_q;
    logic [KEY_ID_BITS-1:0] active_q;
    logic                   live_q;
    logic                   buzz_q;
    logic                   sounding_q;

    logic                   live_ok;
    logic                   song_ok;
    logic                   sel_valid;
    logic                   sel_live;
    logic [KEY_ID_BITS-1:0] sel_id;
    logic                   trigger;
    logic [PH_W-1:0]        half_m1_d;

    always_comb begin
        live_ok   = live_key_pressed && key_valid(live_key_id);
        song_ok   = song_key_is_pressed && key_valid(song_key_id);
        sel_valid = live_ok || song_ok;
        sel_live  = live_ok;
        sel_id    = '0;
        if (live_ok) begin
            sel_id = live_key_id;
        end else if (song_ok) begin
            sel_id = song_key_id;
        end
        // A retrigger pulse only re-strikes the note when the song is the sounding source.
        trigger = sel_valid && ((state_q == S_SILENT) || (sel_id != active_q) ||
                                (sel_live != live_q) || (song_retrigger && !sel_live));
    end

    always_comb begin
        half_m1_d = '0;
        case (int'(sel_id))
            1:       half_m1_d = HM1_C4;
            2:       half_m1_d = HM1_D4;
            3:       half_m1_d = HM1_E4;
            4:       half_m1_d = HM1_F4;
            5:       half_m1_d = HM1_G4;
            6:       half_m1_d = HM1_A4;
            7:       half_m1_d = HM1_B4;
            8:       half_m1_d = HM1_CS4;
            9:       half_m1_d = HM1_DS4;
            10:      half_m1_d = HM1_FS4;
            11:      half_m1_d = HM1_GS4;
            12:      half_m1_d = HM1_AS4;
            default: half_m1_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_SILENT;
            gap_q      <= '0;
            phase_q    <= '0;
            half_m1_q  <= '0;
            active_q   <= '0;
            live_q     <= 1'b0;
            buzz_q     <= 1'b0;
            sounding_q <= 1'b0;
        end else begin
            case (state_q)
                S_SILENT: begin
                    if (trigger) begin
                        active_q  <= sel_id;
                        live_q    <= sel_live;
                        half_m1_q <= half_m1_d;
                        gap_q     <= '0;
                        phase_q   <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q    <= S_TONE;
                            buzz_q     <= 1'b1;
                            sounding_q <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (!sel_valid) begin
                        state_q  <= S_SILENT;
                        active_q <= '0;
                        gap_q    <= '0;
                    end else if (trigger) begin
                        active_q  <= sel_id;
                        live_q    <= sel_live;
                        half_m1_q <= half_m1_d;
                        gap_q     <= '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_q    <= S_TONE;
                        gap_q      <= '0;
                        phase_q    <= '0;
                        buzz_q     <= 1'b1;
                        sounding_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                S_TONE: begin
                    if (!sel_valid) begin
                        state_q    <= S_SILENT;
                        active_q   <= '0;
                        phase_q    <= '0;
                        buzz_q     <= 1'b0;
                        sounding_q <= 1'b0;
                    end else if (trigger) begin
                        active_q  <= sel_id;
                        live_q    <= sel_live;
                        half_m1_q <= half_m1_d;
                        phase_q   <= '0;
                        gap_q     <= '0;
                        // Without a gap a re-strike simply restarts the waveform high.
                        if (GAP_CYCLES == 0) begin
                            buzz_q     <= 1'b1;
                            sounding_q <= 1'b1;
                        end else begin
                            state_q    <= S_GAP;
                            buzz_q     <= 1'b0;
                            sounding_q <= 1'b0;
                        end
                    end else if (phase_q == half_m1_q) begin
                        phase_q <= '0;
                        buzz_q  <= ~buzz_q;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_SILENT;
                    active_q   <= '0;
                    buzz_q     <= 1'b0;
                    sounding_q <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer_out     = buzz_q;
    assign active_key_id  = active_q;
    assign sounding       = sounding_q;
    assign source_is_live = live_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: a 1 ms-gap instance and a no-gap instance at a 100 kHz clock,
// checked every cycle against a timestamp-based note model plus hand-computed timings.
module tb_buzzer_tone_gen;

    localparam int CLK_HZ = 100_000;
    localparam int GAP_G  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] live_id = '0;
    logic       live_pr = 1'b0;
    logic [3:0] song_id = '0;
    logic       song_pr = 1'b0;
    logic       song_rt = 1'b0;

    logic       bz_g, sd_g, sl_g;
    logic [3:0] id_g;
    logic       bz_z, sd_z, sl_z;
    logic [3:0] id_z;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buzzer_tone_gen #(.CLK_FREQ_HZ(CLK_HZ), .KEY_ID_BITS(4), .GAP_MS(1)) dut_g (
        .clk(clk), .rst_n(rst_n),
        .live_key_id(live_id), .live_key_pressed(live_pr),
        .song_key_id(song_id), .song_key_is_pressed(song_pr), .song_retrigger(song_rt),
        .buzzer_out(bz_g), .active_key_id(id_g), .sounding(sd_g), .source_is_live(sl_g)
    );

    buzzer_tone_gen #(.CLK_FREQ_HZ(CLK_HZ), .KEY_ID_BITS(4), .GAP_MS(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .live_key_id(live_id), .live_key_pressed(live_pr),
        .song_key_id(song_id), .song_key_is_pressed(song_pr), .song_retrigger(song_rt),
        .buzzer_out(bz_z), .active_key_id(id_z), .sounding(sd_z), .source_is_live(sl_z)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Note model: a note is (id, source, start edge, half period); outputs follow by arithmetic.
    function automatic bit valid_id(input int id);
        return (id >= 1) && (id <= 12);
    endfunction

    function automatic int half_of(input int id);
        int t50;
        case (id)
            1: t50 = 95556;  2: t50 = 85131;  3: t50 = 75843;  4: t50 = 71586;
            5: t50 = 63776;  6: t50 = 56818;  7: t50 = 50619;  8: t50 = 90193;
            9: t50 = 80353;  10: t50 = 67568; 11: t50 = 60196; 12: t50 = 53629;
            default: t50 = 0;
        endcase
        return int'((longint'(t50) * CLK_HZ + 25_000_000) / 50_000_000);
    endfunction

    int cyc = 0;
    bit m_silent [2] = '{1'b1, 1'b1};
    int m_id     [2] = '{0, 0};
    bit m_live   [2] = '{1'b0, 1'b0};
    int m_start  [2] = '{0, 0};
    int m_half   [2] = '{1, 1};
    int gap_len  [2] = '{GAP_G, 0};

    always @(posedge clk) begin
        bit lo, so, s_live, trig;
        int s_id;
        cyc++;
        lo = live_pr && valid_id(int'(live_id));
        so = song_pr && valid_id(int'(song_id));
        s_live = lo;
        s_id = lo ? int'(live_id) : (so ? int'(song_id) : 0);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_silent[i] = 1'b1;
                m_id[i] = 0;
                m_live[i] = 1'b0;
            end else if (!(lo || so)) begin
                m_silent[i] = 1'b1;
            end else begin
                trig = m_silent[i] || (s_id != m_id[i]) || (s_live != m_live[i]) ||
                       (song_rt && !s_live);
                if (trig) begin
                    m_silent[i] = 1'b0;
                    m_id[i] = s_id;
                    m_live[i] = s_live;
                    m_start[i] = cyc;
                    m_half[i] = half_of(s_id);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                int eb, es, ei, t;
                if (m_silent[i]) begin
                    eb = 0; es = 0; ei = 0;
                end else begin
                    t = cyc - m_start[i];
                    ei = m_id[i];
                    if (t < gap_len[i]) begin
                        eb = 0; es = 0;
                    end else begin
                        es = 1;
                        eb = (((t - gap_len[i]) / m_half[i]) % 2 == 0) ? 1 : 0;
                    end
                end
                chk($sformatf("model_buzz[%0d]", i), int'(i == 0 ? bz_g : bz_z), eb);
                chk($sformatf("model_sounding[%0d]", i), int'(i == 0 ? sd_g : sd_z), es);
                chk($sformatf("model_id[%0d]", i), int'(i == 0 ? id_g : id_z), ei);
                chk($sformatf("model_src[%0d]", i), int'(i == 0 ? sl_g : sl_z), int'(m_live[i]));
            end
        end
    end

    // Counts edges until the gapped instance's buzzer reaches level; -1 if the bound expires.
    task automatic wait_buzz(input logic level, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bz_g != level && n < 2000);
        if (bz_g != level) n = -1;
    endtask

    int n;
    int hi;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_buzz", int'(bz_g), 0);
        chk("rst_sounding", int'(sd_g), 0);
        chk("rst_id", int'(id_g), 0);
        chk("rst_src", int'(sl_g), 0);

        @(negedge clk) rst_n = 1'b1;
        hi = 0;
        repeat (2000) begin
            @(posedge clk);
            #1;
            if (bz_g || sd_g || bz_z || sd_z || id_g != 0) hi++;
        end
        chk("idle_quiet", hi, 0);

        // A4 from the song: 100-cycle gap, then half period 114.
        @(negedge clk);
        song_id = 4'd6;
        song_pr = 1'b1;
        @(posedge clk);
        #1;
        chk("a4_gap_low", int'(bz_g), 0);
        chk("a4_id", int'(id_g), 6);
        chk("a4_nogap_high", int'(bz_z), 1);
        chk("a4_nogap_sounding", int'(sd_z), 1);
        wait_buzz(1'b1, n);
        chk("a4_first_high", n, 100);
        chk("a4_sounding", int'(sd_g), 1);
        wait_buzz(1'b0, n);
        chk("a4_high_len", n, 114);
        wait_buzz(1'b1, n);
        chk("a4_low_len", n, 114);

        // Re-strike of the same note.
        @(negedge clk) song_rt = 1'b1;
        @(posedge clk);
        #1;
        chk("retrig_low", int'(bz_g), 0);
        chk("retrig_sounding", int'(sd_g), 0);
        @(negedge clk) song_rt = 1'b0;
        wait_buzz(1'b1, n);
        chk("retrig_first_high", n, 100);

        // Live E4 preempts, then release returns to the song note.
        repeat (37) @(posedge clk);
        @(negedge clk);
        live_id = 4'd3;
        live_pr = 1'b1;
        @(posedge clk);
        #1;
        chk("live_src", int'(sl_g), 1);
        chk("live_id", int'(id_g), 3);
        chk("live_gap_low", int'(bz_g), 0);
        wait_buzz(1'b1, n);
        chk("e4_first_high", n, 100);
        wait_buzz(1'b0, n);
        chk("e4_high_len", n, 152);
        @(negedge clk) live_pr = 1'b0;
        @(posedge clk);
        #1;
        chk("release_src", int'(sl_g), 0);
        chk("release_id", int'(id_g), 6);
        wait_buzz(1'b1, n);
        chk("resume_first_high", n, 100);
        wait_buzz(1'b0, n);
        chk("resume_high_len", n, 114);

        // Song drops mid-tone, then an invalid ID stays silent.
        repeat (20) @(posedge clk);
        @(negedge clk) song_pr = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_buzz", int'(bz_g), 0);
        chk("drop_sounding", int'(sd_g), 0);
        chk("drop_id", int'(id_g), 0);
        chk("drop_nogap_buzz", int'(bz_z), 0);
        @(negedge clk);
        song_id = 4'd13;
        song_pr = 1'b1;
        hi = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (bz_g || sd_g || bz_z || sd_z || id_g != 0) hi++;
        end
        chk("invalid_quiet", hi, 0);

        // Reset mid-tone with C4 held, then a full gap after release.
        @(negedge clk) song_id = 4'd1;
        @(posedge clk);
        wait_buzz(1'b1, n);
        chk("c4_first_high", n, 100);
        repeat (20) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_buzz", int'(bz_g), 0);
        chk("midrst_sounding", int'(sd_g), 0);
        chk("midrst_id", int'(id_g), 0);
        chk("midrst_nogap_buzz", int'(bz_z), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_id", int'(id_g), 1);
        chk("postrst_low", int'(bz_g), 0);
        chk("postrst_nogap_high", int'(bz_z), 1);
        wait_buzz(1'b1, n);
        chk("postrst_first_high", n, 100);
        wait_buzz(1'b0, n);
        chk("c4_high_len", n, 191);

        // Randomized segments; every cycle is checked against the model.
        for (int seg = 0; seg < 80; seg++) begin
            int dur;
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            live_pr = ($urandom_range(0, 2) == 0);
            live_id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 12));
            song_pr = ($urandom_range(0, 3) != 0);
            song_id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 12));
            if ($urandom_range(0, 4) == 0) live_id = song_id;
            song_rt = 1'b0;
            dur = $urandom_range(1, 450);
            for (int c = 0; c < dur; c++) begin
                @(negedge clk);
                song_rt = ($urandom_range(0, 149) == 0);
            end
        end

        @(negedge clk);
        song_rt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
